// File: rtl/risc_datapath_pkg.sv
// Shared VeriRISC types: opcode and controller state encodings, default widths,
// and the ALU-opcode classifier used by both controller and datapath.
package risc_datapath_pkg;

    localparam int AWIDTH_DEF = 5;
    localparam int DWIDTH_DEF = 8;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    // Phase order matches the controller; the datapath phase counter tracks it 1:1.
    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } state_t;

    function automatic logic is_aluop(opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/risc_datapath_alu.sv
// Combinational VeriRISC ALU: produces the value AC would take for the current
// opcode; non-ALU opcodes pass the accumulator through unchanged.
module risc_alu
    import risc_datapath_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  opcode_t             opcode_i,
    input  logic [DWIDTH-1:0]   accum_i,
    input  logic [DWIDTH-1:0]   data_i,
    output logic [DWIDTH-1:0]   out_o
);

    logic [DWIDTH-1:0] and_bits;
    logic [DWIDTH-1:0] xor_bits;

    for (genvar gi = 0; gi < DWIDTH; gi++) begin : g_bit
        assign and_bits[gi] = accum_i[gi] & data_i[gi];
        assign xor_bits[gi] = accum_i[gi] ^ data_i[gi];
    end

    // ADD is modulo 2^DWIDTH; the carry is intentionally discarded.
    always_comb begin
        out_o = accum_i;
        case (opcode_i)
            ADD:     out_o = accum_i + data_i;
            AND:     out_o = and_bits;
            XOR:     out_o = xor_bits;
            LDA:     out_o = data_i;
            default: out_o = accum_i;
        endcase
    end

endmodule

// File: rtl/risc_datapath.sv
// VeriRISC execution datapath: PC, IR, AC, phase tracker, retired counter and
// the memory address mux, steered by the controller's load/inc/halt strobes.
module risc_datapath
    import risc_datapath_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int CWIDTH = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_ac_i,
    input  logic                load_pc_i,
    input  logic                inc_pc_i,
    input  logic                load_ir_i,
    input  logic                halt_i,
    input  logic [DWIDTH-1:0]   mem_rdata_i,
    output opcode_t             opcode_o,
    output logic                zero_o,
    output logic [AWIDTH-1:0]   mem_addr_o,
    output logic [DWIDTH-1:0]   mem_wdata_o,
    output logic                halted_o,
    output logic [CWIDTH-1:0]   retired_o
);

    if (DWIDTH != AWIDTH + 3) begin : g_width_check
        $error("risc_datapath: DWIDTH must equal AWIDTH+3");
    end

    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [DWIDTH-1:0] ir_q, ir_d;
    logic [DWIDTH-1:0] ac_q, ac_d;
    state_t            phase_q, phase_d;
    logic              halted_q, halted_d;
    logic [CWIDTH-1:0] retired_q, retired_d;
    logic [DWIDTH-1:0] alu_out;
    logic [2:0]        phase_inc;

    assign phase_inc = phase_q + 3'd1;

    risc_alu #(.DWIDTH(DWIDTH)) u_alu (
        .opcode_i (opcode_o),
        .accum_i  (ac_q),
        .data_i   (mem_rdata_i),
        .out_o    (alu_out)
    );

    // A halt edge freezes everything else, including the coincident inc_pc,
    // so PC keeps pointing at the HLT word.
    always_comb begin
        pc_d      = pc_q;
        ir_d      = ir_q;
        ac_d      = ac_q;
        phase_d   = phase_q;
        halted_d  = halted_q;
        retired_d = retired_q;
        if (!halted_q) begin
            if (halt_i) begin
                halted_d = 1'b1;
            end else begin
                phase_d = state_t'(phase_inc);
                if (load_pc_i) begin
                    pc_d = ir_q[AWIDTH-1:0];
                end else if (inc_pc_i) begin
                    pc_d = pc_q + AWIDTH'(1);
                end
                if (load_ir_i) begin
                    ir_d = mem_rdata_i;
                end
                if (load_ac_i) begin
                    ac_d = alu_out;
                end
                if (phase_q == STORE && retired_q != '1) begin
                    retired_d = retired_q + CWIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q      <= '0;
            ir_q      <= '0;
            ac_q      <= '0;
            phase_q   <= INST_ADDR;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            ac_q      <= ac_d;
            phase_q   <= phase_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    // Instruction fetch phases address the PC, operand phases address IR's operand.
    assign mem_addr_o  = (phase_q < OP_ADDR) ? pc_q : ir_q[AWIDTH-1:0];
    assign opcode_o    = opcode_t'(ir_q[AWIDTH +: 3]);
    assign zero_o      = (ac_q == '0);
    assign mem_wdata_o = ac_q;
    assign halted_o    = halted_q;
    assign retired_o   = retired_q;

endmodule
